// File: rtl/ddr_line_burst_reader.sv
// Turns fill-FIFO go pulses into fixed-length PLB master read bursts feeding the line FIFO.
// Optional `BURST_STATS_EN adds burst_count/err_count status counters.
module ddr_line_burst_reader #(
    parameter int unsigned BURST_WORDS = 64,
    parameter int unsigned BEAT_CNT_W  = 7
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Reset,
    input  logic        go_fill_fifo,
    input  logic [31:0] ddr_addr_to_read,
    output logic        IP2Bus_MstRd_Req,
    output logic [31:0] IP2Bus_Mst_Addr,
    output logic [11:0] IP2Bus_Mst_Length,
    input  logic        Bus2IP_Mst_CmdAck,
    input  logic        Bus2IP_Mst_Cmplt,
    input  logic        Bus2IP_Mst_Error,
    input  logic [31:0] Bus2IP_MstRd_d,
    input  logic        Bus2IP_MstRd_src_rdy_n,
    output logic        IP2Bus_MstRd_dst_rdy_n,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic        busy,
    output logic        burst_done,
    output logic        burst_err
`ifdef BURST_STATS_EN
    ,
    output logic [15:0] burst_count,
    output logic [7:0]  err_count
`endif
);

    localparam logic [11:0]           LenBytes = 12'(BURST_WORDS * 4);
    localparam logic [BEAT_CNT_W:0]   ExpBeats = (BEAT_CNT_W + 1)'(BURST_WORDS);
    localparam logic [BEAT_CNT_W-1:0] CntMax   = {BEAT_CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    state_e                r_state, w_state_next;
    logic                  r_pend;
    logic [31:0]           r_pend_addr;
    logic [31:0]           r_addr;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic                  r_err;

    logic                  w_beat;
    logic                  w_cmplt;
    logic                  w_cmplt_err;
    logic                  w_overrun;
    logic [BEAT_CNT_W:0]   w_cnt_sum;

    always_comb begin
        w_state_next           = r_state;
        IP2Bus_MstRd_Req       = 1'b0;
        IP2Bus_MstRd_dst_rdy_n = 1'b1;
        burst_done             = 1'b0;
        w_beat                 = 1'b0;
        unique case (r_state)
            StIdle: if (go_fill_fifo || r_pend) w_state_next = StReq;
            StReq: begin
                IP2Bus_MstRd_Req = 1'b1;
                if (Bus2IP_Mst_CmdAck) w_state_next = StData;
            end
            StData: begin
                IP2Bus_MstRd_dst_rdy_n = fifo_full;
                w_beat = !Bus2IP_MstRd_src_rdy_n && !fifo_full;
                if (Bus2IP_Mst_Cmplt) w_state_next = StDone;
            end
            StDone: begin
                burst_done   = 1'b1;
                w_state_next = (r_pend || go_fill_fifo) ? StReq : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // The beat accepted in the Cmplt cycle counts toward the length check.
    assign w_cnt_sum   = {1'b0, r_beat_cnt} + {{BEAT_CNT_W{1'b0}}, w_beat};
    assign w_cmplt     = (r_state == StData) && Bus2IP_Mst_Cmplt;
    assign w_cmplt_err = w_cmplt && (Bus2IP_Mst_Error || (w_cnt_sum != ExpBeats));
    // Pending is drained in DONE, so a go there is not an overwrite.
    assign w_overrun   = go_fill_fifo && r_pend && (r_state != StIdle) && (r_state != StDone);

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_state     <= StIdle;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_addr      <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (go_fill_fifo) begin
                        r_addr <= ddr_addr_to_read;
                        r_pend <= 1'b0;
                    end else if (r_pend) begin
                        r_addr <= r_pend_addr;
                        r_pend <= 1'b0;
                    end
                end
                StDone: begin
                    if (r_pend) begin
                        r_addr <= r_pend_addr;
                        r_pend <= go_fill_fifo;
                        if (go_fill_fifo) r_pend_addr <= ddr_addr_to_read;
                    end else if (go_fill_fifo) begin
                        r_addr <= ddr_addr_to_read;
                    end
                end
                default: begin
                    if (go_fill_fifo) begin
                        r_pend      <= 1'b1;
                        r_pend_addr <= ddr_addr_to_read;
                    end
                end
            endcase
            if (r_state == StDone) begin
                r_beat_cnt <= '0;
            end else if (w_beat && (r_beat_cnt != CntMax)) begin
                r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            end
            if (w_cmplt_err || w_overrun) r_err <= 1'b1;
        end
    end

    assign IP2Bus_Mst_Addr   = r_addr & 32'hFFFF_FFFC;
    assign IP2Bus_Mst_Length = LenBytes;
    assign fifo_wr_en        = w_beat;
    assign fifo_wr_data      = Bus2IP_MstRd_d;
    assign busy              = (r_state != StIdle) || r_pend;
    assign burst_err         = r_err;

`ifdef BURST_STATS_EN
    logic [15:0] r_burst_count;
    logic [7:0]  r_err_count;
    logic [1:0]  w_err_events;
    logic [8:0]  w_err_sum;

    assign w_err_events = {1'b0, w_cmplt_err} + {1'b0, w_overrun};
    assign w_err_sum    = {1'b0, r_err_count} + {7'd0, w_err_events};

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_burst_count <= '0;
            r_err_count   <= '0;
        end else begin
            if (r_state == StDone) r_burst_count <= r_burst_count + 16'd1;
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign burst_count = r_burst_count;
    assign err_count   = r_err_count;
`endif

endmodule

// File: tb/tb_ddr_line_burst_reader.sv
// Randomized bench for ddr_line_burst_reader: behavioural PLB slave plus a
// transaction-level model of the go/pending/command stream.
module tb_ddr_line_burst_reader;

    localparam int unsigned BurstWords = 64;

    logic        clk = 1'b0;
    logic        rst, go, cmdack, cmplt, merr, src_rdy_n, fifo_full;
    logic [31:0] addr, rd_d;
    logic        req, dst_rdy_n, wr_en, busy, done, err;
    logic [31:0] mst_addr, wr_data;
    logic [11:0] mst_len;
`ifdef BURST_STATS_EN
    logic [15:0] bcnt;
    logic [7:0]  ecnt;
`endif

    always #5 clk = ~clk;

    ddr_line_burst_reader #(
        .BURST_WORDS(BurstWords),
        .BEAT_CNT_W (7)
    ) dut (
        .Bus2IP_Clk            (clk),
        .Bus2IP_Reset          (rst),
        .go_fill_fifo          (go),
        .ddr_addr_to_read      (addr),
        .IP2Bus_MstRd_Req      (req),
        .IP2Bus_Mst_Addr       (mst_addr),
        .IP2Bus_Mst_Length     (mst_len),
        .Bus2IP_Mst_CmdAck     (cmdack),
        .Bus2IP_Mst_Cmplt      (cmplt),
        .Bus2IP_Mst_Error      (merr),
        .Bus2IP_MstRd_d        (rd_d),
        .Bus2IP_MstRd_src_rdy_n(src_rdy_n),
        .IP2Bus_MstRd_dst_rdy_n(dst_rdy_n),
        .fifo_full             (fifo_full),
        .fifo_wr_en            (wr_en),
        .fifo_wr_data          (wr_data),
        .busy                  (busy),
        .burst_done            (done),
        .burst_err             (err)
`ifdef BURST_STATS_EN
        ,
        .burst_count           (bcnt),
        .err_count             (ecnt)
`endif
    );

    int n_cmp = 0, n_bad = 0;

    // Reference model: commands still owed to the bus, in issue order.
    logic [31:0] exp_cmds[$];
    bit          m_cur, m_pend, m_err, m_done, m_after_rst;
    logic [31:0] m_pend_addr;
    int          m_bcnt, m_ecnt;

    // Bus slave state.
    bit          s_data, s_pres, s_errf, s_comb;
    logic [31:0] s_word;
    int          s_len, s_acc, s_ack_wait;

    // Stimulus knobs.
    int          p_go, p_full, p_gap, p_err, p_short, p_long, p_comb, p_rst, ack_fix, force_len;
    int          full_at, full_len, full_cnt;
    bit          sched_go, rst_req;
    logic [31:0] sched_addr, last_cmd;
    int          trig_beat[$];
    logic [31:0] trig_addr[$];
    int          wr_cnt, d_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic pick_ack();
        s_ack_wait = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
    endtask

    task automatic push_cmd(input logic [31:0] a);
        if (exp_cmds.size() == 0) pick_ack();
        exp_cmds.push_back(a);
    endtask

    task automatic err_event();
        m_err = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
    endtask

    task automatic new_burst_params();
        int r;
        r = $urandom_range(0, 99);
        s_len = BurstWords;
        if (force_len > 0) s_len = force_len;
        else if (r < p_short) s_len = $urandom_range(1, BurstWords - 1);
        else if (r < p_short + p_long) s_len = $urandom_range(BurstWords + 1, BurstWords + 6);
        s_errf = pct(p_err);
        s_comb = pct(p_comb);
    endtask

    task automatic model_reset();
        exp_cmds.delete();
        trig_beat.delete();
        trig_addr.delete();
        m_cur = 0; m_pend = 0; m_err = 0; m_done = 0; m_after_rst = 1;
        m_pend_addr = '0; m_bcnt = 0; m_ecnt = 0;
        s_data = 0; s_pres = 0; full_cnt = 0;
        pick_ack();
    endtask

    function automatic bit model_idle();
        return !m_cur && !m_pend && exp_cmds.size() == 0 && !s_data && !m_done;
    endfunction

    task automatic cycle();
        bit do_rst, exp_beat, done_now;
        @(posedge clk);
        #1;
        do_rst = rst_req || ($urandom_range(0, 999) < p_rst);
        rst_req = 0;
        rst = do_rst; go = 0; addr = $urandom; cmdack = 0; cmplt = 0; merr = 0;
        src_rdy_n = 1; rd_d = $urandom; fifo_full = pct(p_full);
        if (!do_rst) begin
            if (sched_go) begin
                go = 1; addr = sched_addr; sched_go = 0;
            end else if (s_data && trig_beat.size() != 0 && trig_beat[0] == s_acc) begin
                go = 1; addr = trig_addr[0];
                void'(trig_beat.pop_front());
                void'(trig_addr.pop_front());
            end else if (pct(p_go)) begin
                go = 1;
            end
            if (!s_data && exp_cmds.size() != 0 && s_ack_wait == 0) cmdack = 1;
            if (s_data) begin
                if (full_len > 0 && s_acc == full_at && full_cnt < full_len) begin
                    fifo_full = 1; full_cnt++;
                end
                if (!s_pres && s_acc < s_len && !pct(p_gap)) begin
                    s_pres = 1; s_word = $urandom;
                end
                if (s_pres) begin
                    src_rdy_n = 0; rd_d = s_word;
                end
                if (s_pres && s_comb && s_acc == s_len - 1) begin
                    cmplt = 1; merr = s_errf; fifo_full = 0;
                end else if (!s_pres && s_acc == s_len) begin
                    cmplt = 1; merr = s_errf;
                end
            end
        end
        #4;
        exp_beat = s_data && s_pres && !fifo_full;
        if (!do_rst) begin
            check_eq("wr_en", wr_en, exp_beat);
            if (exp_beat) check_eq("wr_data", wr_data, s_word);
            check_eq("dst_rdy_n", dst_rdy_n, s_data ? fifo_full : 1'b1);
            check_eq("req", req, exp_cmds.size() != 0);
            if (cmdack) begin
                check_eq("cmd_addr", mst_addr, exp_cmds[0] & 32'hFFFF_FFFC);
                check_eq("cmd_len", mst_len, BurstWords * 4);
                last_cmd = mst_addr;
            end
            check_eq("busy", busy, m_cur || m_pend);
            check_eq("burst_done", done, m_done);
            check_eq("burst_err", err, m_err);
            if (m_after_rst) begin
                check_eq("addr_after_rst", mst_addr, 32'h0);
                m_after_rst = 0;
            end
`ifdef BURST_STATS_EN
            check_eq("burst_count", bcnt, m_bcnt);
            check_eq("err_count", ecnt, m_ecnt);
`endif
            if (wr_en) wr_cnt++;
            if (done) d_cnt++;
        end
        if (do_rst) begin
            model_reset();
            return;
        end
        done_now = m_done;
        m_done = 0;
        if (cmdack) begin
            void'(exp_cmds.pop_front());
            s_data = 1; s_acc = 0; s_pres = 0; full_cnt = 0;
            new_burst_params();
        end else if (exp_cmds.size() != 0) begin
            s_ack_wait--;
        end
        if (exp_beat) begin
            s_acc++; s_pres = 0;
        end
        if (cmplt) begin
            m_done = 1; s_data = 0; s_pres = 0;
            if (merr || s_acc != BurstWords) err_event();
        end
        if (done_now) begin
            m_bcnt = (m_bcnt + 1) % 65536;
            if (m_pend) begin
                push_cmd(m_pend_addr); m_pend = 0;
            end else begin
                m_cur = 0;
            end
        end
        if (go) begin
            if (!m_cur) begin
                m_cur = 1; push_cmd(addr);
            end else if (!m_pend) begin
                m_pend = 1; m_pend_addr = addr;
            end else begin
                m_pend_addr = addr; err_event();
            end
        end
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!model_idle() && n < 3000);
        if (!model_idle()) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_go(input logic [31:0] a);
        sched_go = 1; sched_addr = a;
    endtask

    task automatic do_reset();
        rst_req = 1;
        cycle();
    endtask

    initial begin
        p_go = 0; p_full = 0; p_gap = 0; p_err = 0; p_short = 0; p_long = 0; p_comb = 0;
        p_rst = 0; ack_fix = 2; force_len = 0; full_at = 0; full_len = 0; full_cnt = 0;
        sched_go = 0; rst_req = 0; wr_cnt = 0; d_cnt = 0; last_cmd = '0;
        model_reset();
        do_reset();
        do_reset();

        wr_cnt = 0; d_cnt = 0;
        start_go(32'h1000_0004);
        run_idle();
        check_eq("single_writes", wr_cnt, 64);
        check_eq("single_done", d_cnt, 1);
        check_eq("single_err", err, 0);

        wr_cnt = 0; full_at = 10; full_len = 10;
        start_go(32'h1000_0200);
        run_idle();
        check_eq("bp_writes", wr_cnt, 64);
        full_len = 0;

        wr_cnt = 0; d_cnt = 0;
        trig_beat.push_back(30); trig_addr.push_back(32'h1000_0104);
        start_go(32'h1000_0004);
        run_idle();
        check_eq("queued_writes", wr_cnt, 128);
        check_eq("queued_done", d_cnt, 2);
        check_eq("queued_addr", last_cmd, 32'h1000_0104);
        check_eq("queued_err", err, 0);

        trig_beat.push_back(5);  trig_addr.push_back(32'h2000_0100);
        trig_beat.push_back(15); trig_addr.push_back(32'h2000_0200);
        start_go(32'h2000_0000);
        run_idle();
        check_eq("overrun_addr", last_cmd, 32'h2000_0200);
        check_eq("overrun_err", err, 1);
        do_reset();
        cycle();
        check_eq("rst_clears_err", err, 0);

        force_len = 40;
        start_go(32'h1000_0300);
        run_idle();
        check_eq("short_err", err, 1);
        force_len = 0;
        do_reset();

        p_err = 100;
        start_go(32'h1000_0400);
        run_idle();
        check_eq("buserr_err", err, 1);
        p_err = 0;
        do_reset();

        start_go(32'h3000_0000);
        run_idle();
        start_go(32'h3000_0100);
        for (int i = 0; i < 200 && !(s_data && s_acc == 20); i++) cycle();
        check_eq("reach_beat20", s_acc, 20);
        do_reset();
        cycle();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req", req, 0);
        check_eq("rst_dst_rdy_n", dst_rdy_n, 1);
`ifdef BURST_STATS_EN
        check_eq("rst_burst_count", bcnt, 0);
`endif
        wr_cnt = 0;
        start_go(32'h3000_0200);
        run_idle();
        check_eq("post_rst_writes", wr_cnt, 64);

        p_go = 3; p_full = 20; p_gap = 15; p_err = 5; p_short = 8; p_long = 4; p_comb = 30;
        p_rst = 2; ack_fix = -1;
        repeat (3000) cycle();
        p_go = 0; p_rst = 0;
        run_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
